bit_packer: RTL

Downstream companion of the bit-extraction stage: consumes its variable-length output chunks (0–15 bits, LSB first) and repacks them into contiguous 32-bit words. Packed words are queued in a small output FIFO with back-pressure in both directions. A flush request emits a final partial word. It sits between the bit extractor's pushout/lenout/dataout and any word-wide sink.

---
 rtl/bit_packer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/bit_packer.sv
// bit_packer: repacks 0-15 bit LSB-first chunks into 32-bit words,
// queued in a small word FIFO with flush of the trailing partial word.
module bit_packer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pushin,
  input  logic [3:0]  lenin,
  input  logic [14:0] datain,
  input  logic        flushin,
  output logic        stopin,
  input  logic        stopout,
  output logic        pushout,
  output logic [31:0] dataout,
  output logic [5:0]  bitsout
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] data;
    logic [5:0]  bits;
  } entry_t;

  logic [46:0]   acc_q;
  logic [46:0]   acc_d;
  logic [4:0]    fill_q;
  logic [4:0]    fill_d;

  entry_t        mem [FIFO_DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [CW-1:0] cnt_q;

  logic          acc_push;
  logic          acc_flush;
  logic [15:0]   len_mask;
  logic [14:0]   chunk;
  logic [46:0]   acc_p;
  logic [5:0]    fill_p;
  logic [46:0]   acc_a;
  logic [4:0]    fill_a;
  logic          full_w;
  logic          part_w;
  logic [32:0]   part_mask;
  entry_t        full_e;
  entry_t        part_e;
  entry_t        e0;
  entry_t        e1;
  logic          wr0;
  logic          wr1;
  logic [1:0]    n_wr;
  logic          pop;
  logic          nempty;
  logic [AW-1:0] wptr1;

  // Two writes must always fit, so stall upstream with fewer than 2 free.
  assign stopin = cnt_q > CW'(FIFO_DEPTH - 2);
  assign nempty = cnt_q != '0;
  assign pop    = nempty && !stopout;

  assign pushout = pop;
  assign dataout = nempty ? mem[rptr_q].data : 32'd0;
  assign bitsout = nempty ? mem[rptr_q].bits : 6'd0;

  assign wptr1 = wptr_q + 1'b1;

  // Accumulate the chunk, peel off a full word, then apply any flush.
  always_comb begin
    acc_push  = pushin && !stopin;
    acc_flush = flushin && !stopin;
    len_mask  = (16'h1 << lenin) - 16'h1;
    chunk     = datain & len_mask[14:0];
    acc_p     = acc_q;
    fill_p    = {1'b0, fill_q};
    if (acc_push) begin
      acc_p  = acc_q | ({32'd0, chunk} << fill_q);
      fill_p = {1'b0, fill_q} + {2'b00, lenin};
    end
    full_w = acc_push && fill_p[5];
    full_e = '{data: acc_p[31:0], bits: 6'd32};
    acc_a  = acc_p;
    fill_a = fill_p[4:0];
    if (full_w) begin
      acc_a  = acc_p >> 32;
      fill_a = fill_p[4:0];
    end
    part_w    = acc_flush && (fill_a != 5'd0);
    part_mask = (33'h1 << fill_a) - 33'h1;
    part_e    = '{data: acc_a[31:0] & part_mask[31:0],
                  bits: {1'b0, fill_a}};
    acc_d  = acc_a;
    fill_d = fill_a;
    if (part_w) begin
      acc_d  = '0;
      fill_d = '0;
    end
    e0   = full_w ? full_e : part_e;
    e1   = part_e;
    wr0  = full_w || part_w;
    wr1  = full_w && part_w;
    n_wr = {1'b0, wr0} + {1'b0, wr1};
  end

  // Accumulator and fill count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q  <= '0;
      fill_q <= '0;
    end else begin
      acc_q  <= acc_d;
      fill_q <= fill_d;
    end
  end

  // FIFO pointers and occupancy; up to two writes and one pop per cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_q + AW'(n_wr);
      if (pop) rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_q + CW'(n_wr) - CW'(pop);
    end
  end

  // FIFO storage; contents are only visible through the occupancy count.
  always_ff @(posedge clk) begin
    if (wr0) mem[wptr_q] <= e0;
    if (wr1) mem[wptr1]  <= e1;
  end

endmodule
